semaforo_monitor: RTL and testbench
===================================

SEMAFORO_MONITOR -- requirements
Module: semaforo_monitor

Interface
REQ-001 Parameter T_VERDE_A, default 4, SHALL set the required consecutive cycles of road-A green.
REQ-002 Parameter T_VERDE_B, default 3, SHALL set the required consecutive cycles of road-B green.
REQ-003 Parameter T_AMARELO, default 1, SHALL set the required consecutive cycles of each day yellow.
REQ-004 Parameter T_PISCA, default 1, SHALL set the maximum consecutive cycles of each night pattern (both-yellow or all-off).
REQ-005 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 VmA, AmA, VdA  input  1 each  road-A red, yellow, green lamps, sampled every cycle.
REQ-008 VmB, AmB, VdB  input  1 each  road-B red, yellow, green lamps, sampled every cycle.
REQ-009 clr  input  1  synchronous clear of fault and fault_code.
REQ-010 phase  output  3  registered decoded pattern of the previous cycle's sample.
REQ-011 fault  output  1  sticky fault flag.
REQ-012 fault_code  output  3  code of the first fault since the last clear.
REQ-013 ciclos  output  8  count of completed day cycles, saturating.

Function
REQ-014 Decoding SHALL use the lamp vector {VmA,AmA,VdA,VmB,AmB,VdB}: 001100=AG(1), 010100=AY(2), 100001=BG(3), 100010=BY(4), 010010=NY(5), 000000=OFF(6). Any other value SHALL decode to ILL(7).
REQ-015 phase SHALL equal the decoded value one cycle after the sample.
REQ-016 run_len SHALL count consecutive identical decoded samples. It SHALL be 4 bits, saturate at 15, and be 1 on the first cycle of a new pattern.
REQ-017 CONFLICT (code 010) SHALL be raised when VdA=1 and VdB=1 in a sample.
REQ-018 ILLEGAL (code 001) SHALL be raised when a sample decodes to ILL and is not a CONFLICT.
REQ-019 Permitted successors of each pattern:
- AG->AG or AY.
- AY->AY or BG.
- BG->BG or BY.
- BY->BY or AG.
- NY->OFF or AG.
- OFF->NY or AG.
- Any pattern->NY or OFF (mode interruption).
REQ-020 SEQUENCE (code 011) SHALL be raised on any other pattern change.
REQ-021 The sequence check SHALL be skipped for the first sample after reset and for the sample following an ILL sample (resynchronisation).
REQ-022 TIMING (code 100) SHALL be raised under any of these conditions:
- An AG run reaches T_VERDE_A+1.
- A BG run reaches T_VERDE_B+1.
- An AY or BY run reaches T_AMARELO+1.
- An NY or OFF run reaches T_PISCA+1.
- An AG->AY change occurs with run_len != T_VERDE_A.
- A BG->BY change occurs with run_len != T_VERDE_B.
- An AY->BG or BY->AG change occurs with yellow run_len != T_AMARELO.
REQ-023 A short day run ending in NY or OFF SHALL NOT raise TIMING.
REQ-024 The first AG run after reset or after resynchronisation SHALL be exempt from the short-run check.
REQ-025 Faults from a sample SHALL appear on fault and fault_code in the cycle after the sample (1-cycle latency).
REQ-026 When several faults occur in one sample, priority SHALL be CONFLICT > ILLEGAL > SEQUENCE > TIMING.
REQ-027 fault SHALL stay 1 once set, and fault_code SHALL hold the first fault's code until clr.
REQ-028 clr=1 SHALL zero fault and fault_code on the next edge. If a new fault occurs in the same cycle, the new fault SHALL be latched instead.
REQ-029 ciclos SHALL increment on each valid BY->AG change and saturate at 255.
REQ-030 ciclos SHALL be cleared only by reset.

Reset
REQ-031 While rst=0, all outputs SHALL be forced to 0 (phase=0, fault=0, fault_code=000, ciclos=0).
REQ-032 While rst=0, run_len SHALL be 0 and the first-sample flag SHALL be set, asynchronously.
REQ-033 Reset asserted mid-run SHALL discard all history. After release, the next sample SHALL be treated as first.

Verification
REQ-034 Day loop stimulus: AGx4, AYx1, BGx3, BYx1, repeated 3 times, ending in AG -> fault=0, ciclos=3, phase sequence 1,1,1,1,2,3,3,3,4.
REQ-035 Night stimulus: NY,OFF alternating for 10 cycles, then AG -> fault=0, ciclos=0.
REQ-036 Stimulus: 001001 for one cycle mid-run -> next cycle fault=1, fault_code=010. A following ILL sample -> fault_code stays 010.
REQ-037 Stimulus: AGx5 -> on the cycle after the 5th sample, fault=1, fault_code=100. Then clr=1 -> next cycle fault=0, fault_code=000.
REQ-038 Stimulus: AG then BG directly -> fault_code=011. Separately, BGx2 then NY -> no fault.
REQ-039 Stimulus: rst=0 pulse during BG run -> outputs 0 immediately. After release, BGx1 then BY raises no SEQUENCE fault, and BYx1 then AG increments ciclos to 1.

Source files
------------

// File: rtl/semaforo_monitor_if.sv
// semaforo_monitor_if: lamp samples, clear and monitor verdict outputs
interface semaforo_monitor_if;
    logic       VmA, AmA, VdA, VmB, AmB, VdB, clr;
    logic [2:0] phase;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] ciclos;
    modport master(output VmA, AmA, VdA, VmB, AmB, VdB, clr, input phase, fault, fault_code, ciclos);
    modport slave(input VmA, AmA, VdA, VmB, AmB, VdB, clr, output phase, fault, fault_code, ciclos);
endinterface

// File: rtl/semaforo_monitor.sv
// semaforo_monitor: checks a two-road traffic light for conflicts, illegal lamps,
// bad pattern order and wrong phase durations; counts completed day cycles.
module semaforo_monitor #(
    parameter int T_VERDE_A = 4,
    parameter int T_VERDE_B = 3,
    parameter int T_AMARELO = 1,
    parameter int T_PISCA   = 1
) (
    input logic clk,
    input logic rst,
    semaforo_monitor_if.slave bus
);
    localparam logic [2:0] AG = 3'd1, AY = 3'd2, BG = 3'd3, BY = 3'd4, NY = 3'd5, OFF = 3'd6, ILL = 3'd7;
    logic [5:0] lamps;
    logic [2:0] s, phase_q, code_d, code_q;
    logic [3:0] run_q, run_d;
    logic [7:0] ciclos_q;
    logic       exempt_q, exempt_d, fault_q, first, resync, same, allowed;
    logic       conflict, illegal, seq_err, over, short_run, timing, ciclo_inc;
    int         lim;
    assign lamps = {bus.VmA, bus.AmA, bus.VdA, bus.VmB, bus.AmB, bus.VdB};
    always_comb begin
        s = lamps == 6'b001100 ? AG :
            lamps == 6'b010100 ? AY :
            lamps == 6'b100001 ? BG :
            lamps == 6'b100010 ? BY :
            lamps == 6'b010010 ? NY :
            lamps == 6'b000000 ? OFF : ILL;
        // phase_q is 0 only straight after reset, so it doubles as the first-sample flag
        first  = phase_q == 3'd0;
        resync = first || phase_q == ILL;
        same   = !first && s == phase_q;
        run_d  = same ? (run_q == 4'd15 ? 4'd15 : run_q + 4'd1) : 4'd1;
        allowed = s == phase_q || s == NY || s == OFF ||
                  (phase_q == AG && s == AY) || (phase_q == AY && s == BG) ||
                  (phase_q == BG && s == BY) || (phase_q == BY && s == AG) ||
                  (phase_q == NY && s == AG) || (phase_q == OFF && s == AG);
        conflict = bus.VdA && bus.VdB;
        illegal  = s == ILL && !conflict;
        seq_err  = !resync && !allowed;
        lim = s == AG ? T_VERDE_A :
              s == BG ? T_VERDE_B :
              (s == AY || s == BY) ? T_AMARELO :
              (s == NY || s == OFF) ? T_PISCA : 16;
        over = int'(run_d) == lim + 1;
        short_run = (phase_q == AG && s == AY && !exempt_q && int'(run_q) != T_VERDE_A) ||
                    (phase_q == BG && s == BY && int'(run_q) != T_VERDE_B) ||
                    (((phase_q == AY && s == BG) || (phase_q == BY && s == AG)) && int'(run_q) != T_AMARELO);
        timing = over || short_run;
        code_d = conflict ? 3'b010 : illegal ? 3'b001 : seq_err ? 3'b011 : timing ? 3'b100 : 3'b000;
        ciclo_inc = phase_q == BY && s == AG && int'(run_q) == T_AMARELO;
        // an AG run is exempt from the short check until the first AG run since reset/ILL ends
        exempt_d = s == ILL ? 1'b1 : (phase_q == AG && s != AG) ? 1'b0 : exempt_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= 3'd0;
            run_q    <= 4'd0;
            exempt_q <= 1'b1;
            fault_q  <= 1'b0;
            code_q   <= 3'd0;
            ciclos_q <= 8'd0;
        end else begin
            phase_q  <= s;
            run_q    <= run_d;
            exempt_q <= exempt_d;
            if (code_d != 3'd0 && (!fault_q || bus.clr)) begin
                fault_q <= 1'b1;
                code_q  <= code_d;
            end else if (bus.clr) begin
                fault_q <= 1'b0;
                code_q  <= 3'd0;
            end
            if (ciclo_inc && ciclos_q != 8'd255) ciclos_q <= ciclos_q + 8'd1;
        end
    end
    assign bus.phase      = phase_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.ciclos     = ciclos_q;
endmodule

// File: tb/tb_semaforo_monitor.sv
// tb_semaforo_monitor: directed scenarios plus randomized lamp streams against a history-based model
module tb_semaforo_monitor;
    localparam int TVA = 4, TVB = 3, TAM = 1, TP = 1;
    localparam logic [5:0] AG = 6'b001100, AY = 6'b010100, BG = 6'b100001, BY = 6'b100010, NY = 6'b010010, OFF = 6'b000000;
    logic clk = 0;
    logic rst;
    semaforo_monitor_if bus();
    semaforo_monitor #(.T_VERDE_A(TVA), .T_VERDE_B(TVB), .T_AMARELO(TAM), .T_PISCA(TP)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int errors = 0, checks = 0;
    int hist[$];
    int m_fault, m_code, m_cic, m_phase;
    int dec[64];
    int lim[8];
    bit [7:0] succ[8];
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic int trail();
        int c = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == hist[hist.size() - 1]; i--) c++;
        return c;
    endfunction
    task automatic model(input logic [5:0] v, input logic c);
        int p, n, prv, prun, pr, nrun, code;
        bit first_ag, conf, ill, seq, tim;
        p = dec[v];
        n = hist.size();
        prv = n > 0 ? hist[n - 1] : 0;
        prun = trail();
        pr = prun > 15 ? 15 : prun;
        nrun = (n > 0 && prv == p) ? prun + 1 : 1;
        if (nrun > 15) nrun = 15;
        conf = v[3] && v[0];
        ill = p == 7 && !conf;
        seq = n > 0 && prv != 7 && p != prv && !succ[prv][p];
        first_ag = 1;
        for (int i = n - prun - 1; i >= 0; i--) begin
            if (hist[i] == 7) break;
            if (hist[i] == 1) begin
                first_ag = 0;
                break;
            end
        end
        tim = (nrun == lim[p] + 1) ||
              (n > 0 && ((prv == 1 && p == 2 && !first_ag) || (prv == 3 && p == 4) ||
                         (prv == 2 && p == 3) || (prv == 4 && p == 1)) && pr != lim[prv]);
        code = conf ? 2 : ill ? 1 : seq ? 3 : tim ? 4 : 0;
        if (code != 0 && (m_fault == 0 || c)) begin
            m_fault = 1;
            m_code = code;
        end else if (c) begin
            m_fault = 0;
            m_code = 0;
        end
        if (prv == 4 && p == 1 && pr == TAM && m_cic < 255) m_cic++;
        m_phase = p;
        hist.push_back(p);
    endtask
    task automatic step(input logic [5:0] v, input logic c = 0);
        {bus.VmA, bus.AmA, bus.VdA, bus.VmB, bus.AmB, bus.VdB} = v;
        bus.clr = c;
        @(posedge clk);
        #1;
        model(v, c);
        chk("phase", int'(bus.phase), m_phase);
        chk("fault", int'(bus.fault), m_fault);
        chk("fault_code", int'(bus.fault_code), m_code);
        chk("ciclos", int'(bus.ciclos), m_cic);
    endtask
    task automatic do_reset();
        rst = 0;
        #1;
        chk("rst_phase", int'(bus.phase), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_code", int'(bus.fault_code), 0);
        chk("rst_ciclos", int'(bus.ciclos), 0);
        hist.delete();
        m_fault = 0;
        m_code = 0;
        m_cic = 0;
        m_phase = 0;
        @(negedge clk);
        rst = 1;
    endtask
    initial begin
        logic [5:0] loopv[9] = '{AG, AG, AG, AG, AY, BG, BG, BG, BY};
        int loopp[9] = '{1, 1, 1, 1, 2, 3, 3, 3, 4};
        logic [5:0] pats[6] = '{AG, AY, BG, BY, NY, OFF};
        logic [5:0] dayv[4] = '{AG, AY, BG, BY};
        int dlen[4] = '{TVA, TAM, TVB, TAM};
        int gi, rem, r;
        bit night, nt;
        logic [5:0] v;
        for (int i = 0; i < 64; i++) dec[i] = 7;
        dec[AG] = 1; dec[AY] = 2; dec[BG] = 3; dec[BY] = 4; dec[NY] = 5; dec[OFF] = 6;
        lim = '{0, TVA, TAM, TVB, TAM, TP, TP, 100};
        succ[0] = 8'h00;
        succ[1] = 8'b0110_0100;
        succ[2] = 8'b0110_1000;
        succ[3] = 8'b0111_0000;
        succ[4] = 8'b0110_0010;
        succ[5] = 8'b0100_0010;
        succ[6] = 8'b0010_0010;
        succ[7] = 8'h00;
        {bus.VmA, bus.AmA, bus.VdA, bus.VmB, bus.AmB, bus.VdB} = 6'b0;
        bus.clr = 0;
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 9; i++) begin
                step(loopv[i]);
                if (k == 0) chk("loop_phase", int'(bus.phase), loopp[i]);
            end
        step(AG);
        chk("loop_fault", int'(bus.fault), 0);
        chk("loop_ciclos", int'(bus.ciclos), 3);
        do_reset();
        for (int i = 0; i < 10; i++) step(i % 2 == 0 ? NY : OFF);
        step(AG);
        chk("night_fault", int'(bus.fault), 0);
        chk("night_ciclos", int'(bus.ciclos), 0);
        do_reset();
        step(AG);
        step(AG);
        step(6'b001001);
        chk("conflict_fault", int'(bus.fault), 1);
        chk("conflict_code", int'(bus.fault_code), 2);
        step(6'b111111);
        chk("conflict_hold", int'(bus.fault_code), 2);
        do_reset();
        for (int i = 0; i < 5; i++) step(AG);
        chk("long_fault", int'(bus.fault), 1);
        chk("long_code", int'(bus.fault_code), 4);
        step(AG, 1);
        chk("clr_fault", int'(bus.fault), 0);
        chk("clr_code", int'(bus.fault_code), 0);
        do_reset();
        step(AG);
        step(BG);
        chk("seq_code", int'(bus.fault_code), 3);
        do_reset();
        step(BG);
        step(BG);
        step(NY);
        chk("bg_ny_fault", int'(bus.fault), 0);
        do_reset();
        step(BG);
        step(BG);
        do_reset();
        step(BG);
        step(BY);
        chk("post_rst_code", int'(bus.fault_code), 4);
        step(AG);
        chk("post_rst_ciclos", int'(bus.ciclos), 1);
        chk("post_rst_phase", int'(bus.phase), 1);
        do_reset();
        gi = 0;
        rem = TVA;
        night = 0;
        nt = 0;
        for (int t = 0; t < 3000; t++) begin
            r = $urandom_range(99);
            if (r < 4) v = 6'($urandom_range(63));
            else if (r < 8) v = pats[$urandom_range(5)];
            else if (night) begin
                v = nt ? OFF : NY;
                nt = !nt;
                if ($urandom_range(19) == 0) begin
                    night = 0;
                    gi = 0;
                    rem = TVA;
                end
            end else begin
                if (rem == 0) begin
                    gi = (gi + 1) % 4;
                    rem = dlen[gi] + ($urandom_range(9) == 0 ? 1 : 0) - ($urandom_range(9) == 0 ? 1 : 0);
                    if (rem < 1) rem = 1;
                end
                v = dayv[gi];
                rem--;
                if ($urandom_range(49) == 0) night = 1;
            end
            step(v, $urandom_range(7) == 0);
            if ($urandom_range(299) == 0) do_reset();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
